pe_row_sched: RTL

Sequencer for one row of eight `pe_8e` processing elements running a 3×3, 32-channel convolution. It generates the ifmap SRAM read stream, which feeds PE0 and shifts one PE per cycle down the row. It also generates a per-PE kernel SRAM address stream staggered to match that shift, plus per-PE `valid_in`/`final_in` strobes. It sits between the layer controller (start/config/done) and the PE row plus its SRAMs.

---
 rtl/pe_sched_pkg.sv | 22 ++
 rtl/sched_dly_line.sv | 29 ++
 rtl/pe_row_sched.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pe_sched_pkg.sv
// Shared constants and FSM encoding for the PE row sequencer.
// Ports: none (package).
// Loop-nest sizes and counter widths come from KSIZE and CH_WORDS.
package pe_sched_pkg;

  localparam int KSIZE    = 3;
  localparam int CH_WORDS = 4;
  localparam int TAPS_ROW = KSIZE * CH_WORDS;   // 12 words per kernel row
  localparam int TAPS_ALL = KSIZE * TAPS_ROW;   // 36 MACs per output

  localparam int TAP_W  = $clog2(TAPS_ROW);
  localparam int KROW_W = $clog2(KSIZE);
  localparam int KIDX_W = 6;                    // kernel word index 0..35

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } sched_st_e;

endpackage

// File: rtl/sched_dly_line.sv
// Resettable shift register exposing every stage as a tap.
// Ports: clk/reset (sync, active-high), din (W bits),
//        taps (DEPTH*W bits; slice i is din delayed i+1 cycles).
module sched_dly_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [W-1:0]       din,
  output logic [DEPTH*W-1:0] taps
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_tap
    assign taps[i*W +: W] = stage[i];
  end

endmodule

// File: rtl/pe_row_sched.sv
// Sequencer for one row of PEs: ifmap read stream, staggered per-PE kernel
// reads and valid/final strobes for a 3x3 multi-word-channel convolution.
// Ports: clk, reset (sync, active-high); start + cfg_* from the layer
//        controller; busy/done status; if_rd_en/if_addr to the ifmap SRAM;
//        ker_rd_en/ker_addr (6 bits per PE), pe_valid/pe_final to the PE row.
module pe_row_sched
  import pe_sched_pkg::*;
#(
  parameter int NUM_PE = 8,
  parameter int ADDR_W = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        cfg_base,
  input  logic [ADDR_W-1:0]        cfg_row_stride,
  input  logic [ADDR_W-1:0]        cfg_col_stride,
  input  logic [7:0]               cfg_num_out,
  output logic                     busy,
  output logic                     done,
  output logic                     if_rd_en,
  output logic [ADDR_W-1:0]        if_addr,
  output logic [NUM_PE-1:0]        ker_rd_en,
  output logic [NUM_PE*KIDX_W-1:0] ker_addr,
  output logic [NUM_PE-1:0]        pe_valid,
  output logic [NUM_PE-1:0]        pe_final
);

  localparam int CNT_W = $clog2(NUM_PE + 1);
  localparam logic [TAP_W-1:0]  TAP_LAST   = TAP_W'(TAPS_ROW - 1);
  localparam logic [KROW_W-1:0] KROW_LAST  = KROW_W'(KSIZE - 1);
  localparam logic [KIDX_W-1:0] KIDX_LAST  = KIDX_W'(TAPS_ALL - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(NUM_PE - 1);

  sched_st_e state, state_nxt;

  logic [ADDR_W-1:0] row_stride_q, col_stride_q;
  logic [ADDR_W-1:0] col_ptr;   // base + ocol*col_stride
  logic [ADDR_W-1:0] row_ptr;   // col_ptr + krow*row_stride
  logic [7:0]        num_out_q, ocol;
  logic [KROW_W-1:0] krow;
  logic [TAP_W-1:0]  tap;
  logic [KIDX_W-1:0] kidx;
  logic [CNT_W-1:0]  drain_cnt;

  logic run, accept, last_tap, last_row, last_out, last_read;
  logic [KIDX_W-1:0] ker0_addr;
  logic              fin0;

  assign run       = (state == RUN);
  // The done cycle also takes a new job so back-to-back jobs lose no cycle.
  assign accept    = start && (state == IDLE || state == FIN);
  assign last_tap  = (tap == TAP_LAST);
  assign last_row  = (krow == KROW_LAST);
  assign last_out  = (ocol == num_out_q - 8'd1);
  assign last_read = run && last_tap && last_row && last_out;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    if_rd_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (cfg_num_out == 8'd0) ? FIN : RUN;
      end
      RUN: begin
        busy     = 1'b1;
        if_rd_en = 1'b1;
        if (last_read) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_nxt = FIN;
      end
      FIN: begin
        done = 1'b1;
        if (start) state_nxt = (cfg_num_out == 8'd0) ? FIN : RUN;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      row_stride_q <= '0;
      col_stride_q <= '0;
      num_out_q    <= '0;
      col_ptr      <= '0;
      row_ptr      <= '0;
      ocol         <= '0;
      krow         <= '0;
      tap          <= '0;
      kidx         <= '0;
      drain_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + CNT_W'(1) : '0;
      if (accept) begin
        row_stride_q <= cfg_row_stride;
        col_stride_q <= cfg_col_stride;
        num_out_q    <= cfg_num_out;
        col_ptr      <= cfg_base;
        row_ptr      <= cfg_base;
        ocol         <= '0;
        krow         <= '0;
        tap          <= '0;
        kidx         <= '0;
      end else if (run) begin
        kidx <= (kidx == KIDX_LAST) ? '0 : kidx + KIDX_W'(1);
        if (!last_tap) begin
          tap <= tap + TAP_W'(1);
        end else begin
          tap <= '0;
          if (!last_row) begin
            krow    <= krow + KROW_W'(1);
            row_ptr <= row_ptr + row_stride_q;
          end else begin
            // Next output column: both pointers restart from the new column.
            krow    <= '0;
            ocol    <= ocol + 8'd1;
            col_ptr <= col_ptr + col_stride_q;
            row_ptr <= col_ptr + col_stride_q;
          end
        end
      end
    end
  end

  // Outputs are forced to 0 outside RUN so idle buses stay quiet.
  assign if_addr   = run ? row_ptr + ADDR_W'(tap) : '0;
  assign ker0_addr = run ? kidx : '0;
  assign fin0      = run && (kidx == KIDX_LAST);

  // Kernel stream: PE0 is undelayed, PE k sees it k cycles later.
  logic [(NUM_PE-1)*(KIDX_W+1)-1:0] ker_taps;

  sched_dly_line #(.W(KIDX_W + 1), .DEPTH(NUM_PE - 1)) u_ker_dly (
    .clk   (clk),
    .reset (reset),
    .din   ({if_rd_en, ker0_addr}),
    .taps  (ker_taps)
  );

  assign ker_rd_en[0]          = if_rd_en;
  assign ker_addr[KIDX_W-1:0]  = ker0_addr;
  for (genvar k = 1; k < NUM_PE; k++) begin : g_ker
    assign {ker_rd_en[k], ker_addr[k*KIDX_W +: KIDX_W]} =
      ker_taps[(k-1)*(KIDX_W+1) +: KIDX_W+1];
  end

  // Valid/final: one extra cycle for SRAM read latency, then k more for PE k.
  logic [NUM_PE*2-1:0] vf_taps;

  sched_dly_line #(.W(2), .DEPTH(NUM_PE)) u_vf_dly (
    .clk   (clk),
    .reset (reset),
    .din   ({if_rd_en, fin0}),
    .taps  (vf_taps)
  );

  for (genvar k = 0; k < NUM_PE; k++) begin : g_vf
    assign {pe_valid[k], pe_final[k]} = vf_taps[k*2 +: 2];
  end

endmodule
